// File: rtl/sync_fifo.sv
// Show-ahead single-clock FIFO: head entry visible on oRD_DATA, one cycle write-to-read latency.
// Backpressure via oWR_FULL (writes while full are dropped); reads while empty are ignored.
module sync_fifo #(
    parameter int P_N       = 16,
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    output logic [P_DEPTH_N:0]   oCOUNT,
    input  logic                 iWR_EN,
    input  logic [P_N-1:0]       iWR_DATA,
    output logic                 oWR_FULL,
    input  logic                 iRD_EN,
    output logic [P_N-1:0]       oRD_DATA,
    output logic                 oRD_EMPTY
);

    localparam logic [P_DEPTH_N:0] PTR_ONE = 1;

    logic [P_N-1:0]     mem [P_DEPTH];
    logic [P_DEPTH_N:0] wptr;
    logic [P_DEPTH_N:0] rptr;
    logic               wr_ok;
    logic               rd_ok;

    // Flags come straight from the pointers; the extra MSB separates full from empty.
    assign oRD_EMPTY = (wptr == rptr);
    assign oWR_FULL  = (wptr[P_DEPTH_N] != rptr[P_DEPTH_N]) &&
                       (wptr[P_DEPTH_N-1:0] == rptr[P_DEPTH_N-1:0]);
    assign oCOUNT    = wptr - rptr;
    assign oRD_DATA  = mem[rptr[P_DEPTH_N-1:0]];

    assign wr_ok = iWR_EN && !oWR_FULL;
    assign rd_ok = iRD_EN && !oRD_EMPTY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) rptr <= rptr + PTR_ONE;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge iCLOCK) begin
        if (wr_ok) mem[wptr[P_DEPTH_N-1:0]] <= iWR_DATA;
    end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    localparam int N  = 64;
    localparam int D  = 8;
    localparam int DN = 3;

    logic          clk;
    logic          rst_n;
    logic [DN:0]   count;
    logic          wr_en;
    logic [N-1:0]  wr_dat;
    logic          wr_full;
    logic          rd_en;
    logic [N-1:0]  rd_dat;
    logic          rd_empty;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] q[$];

    sync_fifo #(.P_N(N), .P_DEPTH(D), .P_DEPTH_N(DN)) dut (
        .iCLOCK   (clk),
        .inRESET  (rst_n),
        .oCOUNT   (count),
        .iWR_EN   (wr_en),
        .iWR_DATA (wr_dat),
        .oWR_FULL (wr_full),
        .iRD_EN   (rd_en),
        .oRD_DATA (rd_dat),
        .oRD_EMPTY(rd_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: pre-edge flags decide acceptance, then the queue moves.
    always @(posedge clk) begin
        if (rst_n) begin
            automatic bit m_full  = (q.size() == D);
            automatic bit m_empty = (q.size() == 0);
            if (rd_en && !m_empty) void'(q.pop_front());
            if (wr_en && !m_full) q.push_back(wr_dat);
        end
    end

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_count", 64'(count), 64'(q.size()));
            check("model_empty", 64'(rd_empty), 64'(q.size() == 0));
            check("model_full", 64'(wr_full), 64'(q.size() == D));
            if (q.size() > 0) check("model_head", rd_dat, q[0]);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc;
        int rc;
        int cyc;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wr_dat = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 64'(rd_empty), 64'd1);
        check("rst_full", 64'(wr_full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        rd_en = 1'b1;
        step();
        check("rst_pop_ignored_count", 64'(count), 64'd0);
        check("rst_pop_ignored_empty", 64'(rd_empty), 64'd1);
        rd_en = 1'b0;

        // Fill to full, then one dropped write.
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_dat = 64'((i + 1) * 'h11);
            step();
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("fill_full", 64'(wr_full), 64'd1);
        wr_dat = 64'h99;
        step();
        check("overflow_count", 64'(count), 64'd8);
        check("overflow_head", rd_dat, 64'h11);
        wr_en = 1'b0;

        // Drain in order.
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_data", rd_dat, 64'((i + 1) * 'h11));
            step();
        end
        check("drain_empty", 64'(rd_empty), 64'd1);
        check("drain_count", 64'(count), 64'd0);
        step();
        check("underflow_count", 64'(count), 64'd0);
        rd_en = 1'b0;

        // Simultaneous read/write at count 3.
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_dat = 64'('hA1 + i);
            step();
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            automatic logic [63:0] exp_head = (i < 3) ? 64'('hA1 + i) : 64'hB1;
            check("rw3_head", rd_dat, exp_head);
            wr_dat = 64'('hB1 + i);
            step();
            check("rw3_count", 64'(count), 64'd3);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rw3_tail", rd_dat, 64'('hB2 + i));
            step();
        end
        rd_en = 1'b0;

        // Simultaneous read/write while full: write dropped.
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_dat = 64'('hC0 + i);
            step();
        end
        check("rwfull_full", 64'(wr_full), 64'd1);
        rd_en  = 1'b1;
        wr_dat = 64'hEE;
        step();
        check("rwfull_count", 64'(count), 64'd7);
        check("rwfull_head", rd_dat, 64'hC1);
        wr_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("rwfull_drain", rd_dat, 64'('hC1 + i));
            step();
        end
        check("rwfull_empty", 64'(rd_empty), 64'd1);

        // Simultaneous read/write while empty: read ignored.
        wr_en  = 1'b1;
        wr_dat = 64'hD5;
        step();
        check("rwempty_count", 64'(count), 64'd1);
        check("rwempty_data", rd_dat, 64'hD5);
        check("rwempty_empty", 64'(rd_empty), 64'd0);
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        check("rwempty_popped", 64'(count), 64'd0);

        // Streaming across pointer wrap with 1..5 entries queued.
        wc  = 0;
        rc  = 0;
        cyc = 0;
        while (rc < 20 && cyc < 100) begin
            wr_en  = (wc < 20) && (q.size() < 5);
            wr_dat = 64'('h100 + wc);
            rd_en  = ((q.size() > 1) && (cyc % 3 != 0)) || (wc == 20 && q.size() > 0);
            if (rd_en) begin
                check("wrap_data", rd_dat, 64'('h100 + rc));
                rc++;
            end
            if (wr_en) wc++;
            step();
            cyc++;
        end
        if (rc < 20) begin
            failures++;
            $display("FAIL wrap_timeout read=%0d expected=20", rc);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wrap_empty", 64'(rd_empty), 64'd1);

        // Asynchronous reset with 5 entries queued.
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_dat = 64'('h50 + i);
            step();
        end
        wr_en = 1'b0;
        check("midrst_pre_count", 64'(count), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_empty", 64'(rd_empty), 64'd1);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_full", 64'(wr_full), 64'd0);
        step();
        rst_n  = 1'b1;
        wr_en  = 1'b1;
        wr_dat = 64'hAB;
        step();
        wr_en = 1'b0;
        check("postrst_data", rd_dat, 64'hAB);
        check("postrst_count", 64'(count), 64'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
